// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding and sizing helpers for the serial arithmetic blocks
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_state_e;

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  // Bit counter only needs to reach width-1, but never shrinks below one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand and result handshakes of the serial adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - single combinational full-adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder: one full-adder cell, LSB-first, valid/ready on both sides
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ss_q, ss_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;

  full_adder u_fa (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ss_d    = ss_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          carry_d = bus.cin;
          ss_d    = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts.
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        ss_d    = {fa_s, ss_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == CNT_LAST) begin
          c_msb_d = carry_q;
          cout_d  = fa_co;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ss_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ss_q    <= ss_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.sum       = ss_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = c_msb_q ^ cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8 and 13
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(13)) bus13 ();

  serial_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder #(.WIDTH(13)) u_dut13 (.clk(clk), .rst(rst), .bus(bus13));

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          t;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc8  = 0;
  int   acc13 = 0;
  exp_t q8[$];
  exp_t q13[$];
  bit   hold8 = 0, hold13 = 0, pov8 = 0, pov13 = 0;
  bit   thru_on = 0;
  int   thru_prev = -1;
  int   thru_hs = 0;
  bit   done13 = 0;

  function automatic logic [63:0] mask_of(input int w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input int t);
    exp_t        e;
    logic [64:0] full;
    logic [63:0] m;
    m      = mask_of(w);
    full   = {1'b0, a & m} + {1'b0, b & m} + 65'(cin);
    e.sum  = full[63:0] & m;
    e.cout = full[w];
    e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    e.t    = t;
    return e;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] m;
    m = mask_of(w);
    case ($urandom_range(7))
      0:       return 64'd0;
      1:       return m;
      2:       return 64'd1 << (w - 1);
      3:       return (64'd1 << (w - 1)) - 64'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every negedge, compare both DUTs against the pending-result queues.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q8.delete();
      q13.delete();
      hold8  = 0;
      hold13 = 0;
    end
    chk("in_ready8", bus8.in_ready, !rst && q8.size() == 0);
    chk("in_ready13", bus13.in_ready, !rst && q13.size() == 0);
    if (!rst) begin
      if (hold8) chk("hold8", bus8.out_valid, 1);
      if (bus8.out_valid) begin
        if (q8.size() == 0) chk("spurious8", bus8.out_valid, 0);
        else begin
          if (!pov8) chk("latency8", cyc - q8[0].t, 9);
          chk("sum8", bus8.sum, q8[0].sum);
          chk("cout8", bus8.cout, q8[0].cout);
          chk("ovf8", bus8.ovf, q8[0].ovf);
          if (bus8.out_ready) begin
            if (thru_on) begin
              if (thru_prev >= 0) chk("period8", cyc - thru_prev, 10);
              thru_prev = cyc;
              thru_hs++;
            end
            void'(q8.pop_front());
          end
        end
      end
      hold8 = bus8.out_valid && !bus8.out_ready;
      if (bus8.in_valid && bus8.in_ready) begin
        q8.push_back(model(8, 64'(bus8.a), 64'(bus8.b), bus8.cin, cyc));
        acc8++;
      end

      if (hold13) chk("hold13", bus13.out_valid, 1);
      if (bus13.out_valid) begin
        if (q13.size() == 0) chk("spurious13", bus13.out_valid, 0);
        else begin
          if (!pov13) chk("latency13", cyc - q13[0].t, 14);
          chk("sum13", bus13.sum, q13[0].sum);
          chk("cout13", bus13.cout, q13[0].cout);
          chk("ovf13", bus13.ovf, q13[0].ovf);
          if (bus13.out_ready) void'(q13.pop_front());
        end
      end
      hold13 = bus13.out_valid && !bus13.out_ready;
      if (bus13.in_valid && bus13.in_ready) begin
        q13.push_back(model(13, 64'(bus13.a), 64'(bus13.b), bus13.cin, cyc));
        acc13++;
      end
    end
    pov8  = bus8.out_valid && !rst;
    pov13 = bus13.out_valid && !rst;
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n = 0;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b1;
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = c;
    do begin
      @(negedge clk);
      n++;
    end while (!bus8.in_ready && n < 100);
    chk("accept8", bus8.in_ready, 1);
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
  endtask

  task automatic wait_ov8();
    int n = 0;
    while (!bus8.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ov_seen8", bus8.out_valid, 1);
  endtask

  initial begin : drv13
    int n;
    n = 0;
    bus13.in_valid  = 1'b0;
    bus13.a         = '0;
    bus13.b         = '0;
    bus13.cin       = 1'b0;
    bus13.out_ready = 1'b1;
    while (rst) @(posedge clk);
    while (acc13 < 1000 && n < 60000) begin
      @(posedge clk);
      #1;
      bus13.in_valid  = ($urandom_range(3) != 0);
      bus13.a         = 13'(pick(13));
      bus13.b         = 13'(pick(13));
      bus13.cin       = 1'($urandom_range(1));
      bus13.out_ready = ($urandom_range(2) != 0);
      n++;
    end
    chk("rand13_count", acc13 >= 1000, 1);
    bus13.in_valid  = 1'b0;
    bus13.out_ready = 1'b1;
    done13 = 1;
  end

  initial begin : main
    exp_t e;
    int   n;
    int   start;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.cin       = 1'b0;
    bus8.out_ready = 1'b1;

    e = model(8, 64'h5A, 64'h33, 1'b0, 0);
    chk("model_5a33", {e.ovf, e.cout, e.sum[7:0]}, 10'b1_0_1000_1101);
    e = model(8, 64'hFF, 64'h01, 1'b0, 0);
    chk("model_ff01", {e.ovf, e.cout, e.sum[7:0]}, 10'b0_1_0000_0000);
    e = model(8, 64'h7F, 64'h00, 1'b1, 0);
    chk("model_7f00c", {e.ovf, e.cout, e.sum[7:0]}, 10'b1_0_1000_0000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus8.out_valid, 0);
    chk("rst_sum", bus8.sum, 0);
    chk("rst_cout", bus8.cout, 0);
    chk("rst_ovf", bus8.ovf, 0);
    chk("rst_in_ready", bus8.in_ready, 1);

    send8(8'h5A, 8'h33, 1'b0);
    wait_ov8();
    chk("lit_5a33_sum", bus8.sum, 8'h8D);
    chk("lit_5a33_cout", bus8.cout, 0);
    chk("lit_5a33_ovf", bus8.ovf, 1);
    send8(8'hFF, 8'h01, 1'b0);
    wait_ov8();
    chk("lit_ff01_sum", bus8.sum, 8'h00);
    chk("lit_ff01_cout", bus8.cout, 1);
    chk("lit_ff01_ovf", bus8.ovf, 0);
    send8(8'h7F, 8'h00, 1'b1);
    wait_ov8();
    chk("lit_7f00_sum", bus8.sum, 8'h80);
    chk("lit_7f00_cout", bus8.cout, 0);
    chk("lit_7f00_ovf", bus8.ovf, 1);

    // Backpressure: hold the result while new operands wait at the input.
    @(posedge clk);
    #1 bus8.out_ready = 1'b0;
    send8(8'h70, 8'h20, 1'b1);
    wait_ov8();
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b1;
    bus8.a        = 8'hAA;
    bus8.b        = 8'h55;
    bus8.cin      = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_sum", bus8.sum, 8'h91);
      chk("bp_cout", bus8.cout, 0);
      chk("bp_ovf", bus8.ovf, 1);
      chk("bp_in_ready", bus8.in_ready, 0);
    end
    @(posedge clk);
    #1 bus8.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", bus8.out_valid, 1);
    chk("bp_hs_in_ready", bus8.in_ready, 0);
    @(negedge clk);
    chk("bp_idle_in_ready", bus8.in_ready, 1);
    chk("bp_idle_valid", bus8.out_valid, 0);
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    wait_ov8();
    chk("bp_next_sum", bus8.sum, 8'hFF);
    chk("bp_next_cout", bus8.cout, 0);
    chk("bp_next_ovf", bus8.ovf, 0);

    // Reset in the third RUN cycle discards the operation.
    send8(8'h77, 8'h66, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", bus8.out_valid, 0);
    chk("mid_rst_sum", bus8.sum, 0);
    chk("mid_rst_cout", bus8.cout, 0);
    chk("mid_rst_ovf", bus8.ovf, 0);
    chk("mid_rst_in_ready", bus8.in_ready, 1);
    repeat (15) @(negedge clk);
    send8(8'h10, 8'h20, 1'b0);
    wait_ov8();
    chk("after_rst_sum", bus8.sum, 8'h30);
    chk("after_rst_cout", bus8.cout, 0);

    // Back-to-back throughput with both handshakes tied high.
    @(posedge clk);
    #1;
    thru_prev = -1;
    thru_hs   = 0;
    thru_on   = 1;
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus8.a   = 8'($urandom);
      bus8.b   = 8'($urandom);
      bus8.cin = 1'($urandom_range(1));
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus8.in_ready && n < 50);
      @(posedge clk);
      #1;
    end
    bus8.in_valid = 1'b0;
    n = 0;
    while (thru_hs < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("thru_count", thru_hs, 4);
    thru_on = 0;

    // Random traffic with random backpressure.
    start = acc8;
    n = 0;
    while (acc8 - start < 1000 && n < 40000) begin
      @(posedge clk);
      #1;
      bus8.in_valid  = ($urandom_range(3) != 0);
      bus8.a         = 8'(pick(8));
      bus8.b         = 8'(pick(8));
      bus8.cin       = 1'($urandom_range(1));
      bus8.out_ready = ($urandom_range(2) != 0);
      n++;
    end
    chk("rand8_count", acc8 - start >= 1000, 1);
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;

    n = 0;
    while (!done13 && n < 70000) begin
      @(posedge clk);
      n++;
    end
    chk("done13", done13, 1);
    repeat (40) @(negedge clk);
    chk("drain8", q8.size(), 0);
    chk("drain13", q13.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
